// File: rtl/laser_packetizer.sv
// ---------------------------------------------------------------------------
// laser_packetizer
//
// Drains host bytes from the FTDI read queue and frames them for the laser
// transmit serializer.  The read queue is a normal-mode FIFO: data_rd is valid
// on the cycle after rdreq.
//
// Frame layout: SYNC, SEQ, LEN, payload[LEN], CSUM
//   CSUM = SEQ ^ LEN ^ payload[0] ^ ... ^ payload[LEN-1]  (SYNC excluded)
//
// A full packet (PAYLOAD_LEN bytes) goes out as soon as enough bytes are
// queued.  A shorter packet is flushed once the queue has sat non-empty but
// below the full level for FLUSH_CYCLES idle cycles.
//
// Parameters
//   PAYLOAD_LEN   maximum payload bytes per packet (1..255)
//   SYNC_BYTE     first byte of every frame
//   FLUSH_CYCLES  idle cycles before a partial flush (>= 2)
//
// Ports
//   clock      in   system clock, all logic on its rising edge
//   reset      in   synchronous active-high reset
//   clear      in   synchronous abort, identical in effect to reset
//   enable     in   permits new packets to start (never aborts one)
//   rdq_empty  in   read queue empty flag
//   qsize      in   read queue fill level in bytes
//   data_rd    in   read queue output, valid the cycle after rdreq
//   rdreq      out  read queue pop request (combinational state decode)
//   tx_ready   in   downstream accepts tx_data this cycle
//   tx_valid   out  tx_data valid
//   tx_data    out  frame byte
//   tx_sop     out  marks the SYNC byte
//   tx_eop     out  marks the CSUM byte
//   busy       out  high whenever a packet is in progress
//   seq_num    out  sequence number of the current/next packet
// ---------------------------------------------------------------------------
module laser_packetizer #(
  parameter int         PAYLOAD_LEN  = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         FLUSH_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       rdq_empty,
  input  logic [9:0] qsize,
  input  logic [7:0] data_rd,
  output logic       rdreq,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       tx_sop,
  output logic       tx_eop,
  output logic       busy,
  output logic [7:0] seq_num
);

  localparam int              FW         = $clog2(FLUSH_CYCLES);
  localparam logic [FW-1:0]   FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [9:0]      FULL_LEVEL = 10'(PAYLOAD_LEN);
  localparam logic [7:0]      FULL_LEN   = 8'(PAYLOAD_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_SEQ,
    S_LEN,
    S_FETCH,
    S_LOAD,
    S_PAYLOAD,
    S_CSUM
  } state_t;

  state_t        state;
  logic [7:0]    len;
  logic [7:0]    remaining;
  logic [7:0]    csum;
  logic [FW-1:0] flush_count;

  logic       transfer;
  logic       start_full;
  logic       start_flush;
  logic       start;
  logic [7:0] start_len;

  assign transfer = tx_valid && tx_ready;

  // A full packet wins over a timed-out partial flush.  A flush is only
  // possible below the full level, so qsize fits in eight bits there and
  // is never zero because the queue is known to be non-empty.
  assign start_full  = enable && (qsize >= FULL_LEVEL);
  assign start_flush = enable && !rdq_empty && (flush_count == FLUSH_LAST);
  assign start       = start_full || start_flush;
  assign start_len   = start_full ? FULL_LEN : qsize[7:0];

  // Pop only when there is something to pop; an empty queue simply stalls
  // the fetch until a byte arrives.
  assign rdreq = (state == S_FETCH) && !rdq_empty;

  // Idle timer for partial flushes.  It runs only while a short,
  // non-empty queue is waiting in IDLE and parks at its last value so a
  // flush fires as soon as enable allows.  With enable low and a full
  // queue it neither runs nor clears.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      flush_count <= '0;
    end else if (state != S_IDLE || rdq_empty || start) begin
      flush_count <= '0;
    end else if (qsize < FULL_LEVEL && flush_count != FLUSH_LAST) begin
      flush_count <= flush_count + FW'(1);
    end
  end

  // Framing state machine.  Every output is set up on the way into the
  // state that presents it, so tx_data/tx_sop/tx_eop stay put while the
  // downstream stalls.  The checksum is folded in as each byte is accepted;
  // on the last payload byte the finished checksum is loaded straight into
  // tx_data so CSUM is presented on the very next cycle.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state     <= S_IDLE;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      tx_sop    <= 1'b0;
      tx_eop    <= 1'b0;
      busy      <= 1'b0;
      seq_num   <= '0;
      len       <= '0;
      remaining <= '0;
      csum      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len       <= start_len;
            remaining <= start_len;
            csum      <= '0;
            tx_valid  <= 1'b1;
            tx_data   <= SYNC_BYTE;
            tx_sop    <= 1'b1;
            busy      <= 1'b1;
            state     <= S_SYNC;
          end
        end

        S_SYNC: begin
          if (transfer) begin
            tx_sop  <= 1'b0;
            tx_data <= seq_num;
            state   <= S_SEQ;
          end
        end

        S_SEQ: begin
          if (transfer) begin
            csum    <= csum ^ seq_num;
            tx_data <= len;
            state   <= S_LEN;
          end
        end

        S_LEN: begin
          if (transfer) begin
            csum     <= csum ^ len;
            tx_valid <= 1'b0;
            state    <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (!rdq_empty) begin
            state <= S_LOAD;
          end
        end

        S_LOAD: begin
          tx_data  <= data_rd;
          tx_valid <= 1'b1;
          state    <= S_PAYLOAD;
        end

        S_PAYLOAD: begin
          if (transfer) begin
            csum      <= csum ^ tx_data;
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) begin
              tx_data <= csum ^ tx_data;
              tx_eop  <= 1'b1;
              state   <= S_CSUM;
            end else begin
              tx_valid <= 1'b0;
              state    <= S_FETCH;
            end
          end
        end

        S_CSUM: begin
          if (transfer) begin
            tx_valid <= 1'b0;
            tx_eop   <= 1'b0;
            busy     <= 1'b0;
            seq_num  <= seq_num + 8'd1;
            state    <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_laser_packetizer.sv
// ---------------------------------------------------------------------------
// tb_laser_packetizer
//
// Bench for laser_packetizer with PAYLOAD_LEN=4 and FLUSH_CYCLES=8.  A small
// normal-mode FIFO model feeds the read side.  Every byte pushed is also
// queued as pending payload; when the bench knows a packet will be formed it
// builds the whole expected frame (SYNC, SEQ, LEN, payload, CSUM) into a
// scoreboard, and every accepted tx beat is compared against its head.
// ---------------------------------------------------------------------------
module tb_laser_packetizer;

  localparam int         PL   = 4;
  localparam int         FC   = 8;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clock = 1'b0;
  logic       reset;
  logic       clear;
  logic       enable;
  logic       rdq_empty;
  logic [9:0] qsize;
  logic [7:0] data_rd = 8'h00;
  logic       rdreq;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_sop;
  logic       tx_eop;
  logic       busy;
  logic [7:0] seq_num;

  always #5 clock = ~clock;

  laser_packetizer #(
    .PAYLOAD_LEN (PL),
    .SYNC_BYTE   (SYNC),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .enable   (enable),
    .rdq_empty(rdq_empty),
    .qsize    (qsize),
    .data_rd  (data_rd),
    .rdreq    (rdreq),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_sop   (tx_sop),
    .tx_eop   (tx_eop),
    .busy     (busy),
    .seq_num  (seq_num)
  );

  // Read queue model: push lands on the clock edge, pop data appears on
  // data_rd one edge after rdreq.
  logic       push_en   = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic [7:0] fifo_mem [0:1023];
  logic [9:0] wr_ptr     = '0;
  logic [9:0] rd_ptr     = '0;
  logic [9:0] fifo_count = '0;
  int         pop_total  = 0;

  always @(posedge clock) begin
    if (push_en) begin
      fifo_mem[wr_ptr] <= push_data;
      wr_ptr <= wr_ptr + 10'd1;
    end
    if (rdreq) begin
      data_rd   <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 10'd1;
      pop_total <= pop_total + 1;
    end
    fifo_count <= fifo_count + 10'(push_en) - 10'(rdreq);
  end

  assign rdq_empty = (fifo_count == 10'd0);
  assign qsize     = fifo_count;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;

  beat_t      sb[$];
  logic [7:0] pend[$];
  logic [7:0] model_seq = 8'h00;
  int         total = 0;
  int         bad   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic beat_t mkBeat(input logic [7:0] d, input logic s, input logic e);
    beat_t b;
    b.data = d;
    b.sop  = s;
    b.eop  = e;
    return b;
  endfunction

  // Build the full expected frame for the next n pending bytes.
  task automatic expectPacket(input int n);
    logic [7:0] c;
    logic [7:0] b;
    c = model_seq ^ 8'(n);
    sb.push_back(mkBeat(SYNC, 1'b1, 1'b0));
    sb.push_back(mkBeat(model_seq, 1'b0, 1'b0));
    sb.push_back(mkBeat(8'(n), 1'b0, 1'b0));
    for (int i = 0; i < n; i++) begin
      b = pend.pop_front();
      c = c ^ b;
      sb.push_back(mkBeat(b, 1'b0, 1'b0));
    end
    sb.push_back(mkBeat(c, 1'b0, 1'b1));
    model_seq = model_seq + 8'd1;
  endtask

  // Push one byte into the read queue; called at a falling edge.
  task automatic applyStimulus(input logic [7:0] b);
    push_data = b;
    push_en   = 1'b1;
    pend.push_back(b);
    @(negedge clock);
    push_en = 1'b0;
  endtask

  // Wait until every expected beat has gone out and the block is idle.
  task automatic waitDrain(input int limit, input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || tx_valid) && n < limit) begin
      @(negedge clock);
      n++;
    end
    checkOutput({tag, "_drained"}, 32'(n < limit), 32'd1);
  endtask

  // Output side: drive tx_ready, compare accepted beats, and make sure a
  // stalled beat is held unchanged into the next cycle.
  logic  rand_ready = 1'b0;
  logic  prev_stall = 1'b0;
  logic  [7:0] prev_data;
  logic  prev_sop;
  logic  prev_eop;
  beat_t exp_beat;

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clock);
      if (prev_stall) begin
        checkOutput("stall_valid", 32'(tx_valid), 32'd1);
        checkOutput("stall_data", 32'(tx_data), 32'(prev_data));
        checkOutput("stall_sop", 32'(tx_sop), 32'(prev_sop));
        checkOutput("stall_eop", 32'(tx_eop), 32'(prev_eop));
      end
      if (rdreq) begin
        checkOutput("rdreq_while_empty", 32'(rdq_empty), 32'd0);
      end
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid && tx_ready) begin
        checkOutput("beat_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_beat = sb.pop_front();
          checkOutput("tx_data", 32'(tx_data), 32'(exp_beat.data));
          checkOutput("tx_sop", 32'(tx_sop), 32'(exp_beat.sop));
          checkOutput("tx_eop", 32'(tx_eop), 32'(exp_beat.eop));
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_sop   = tx_sop;
      prev_eop   = tx_eop;
    end
  end

  // Hard stop in case something wedges beyond every bounded wait.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int p0;
    int n;
    logic found;
    logic [7:0] r;

    reset  = 1'b1;
    clear  = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_seq_num", 32'(seq_num), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_sop_eop", 32'({tx_sop, tx_eop}), 32'd0);
    checkOutput("rst_rdreq", 32'(rdreq), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Full packet, downstream always ready.
    $display("[TB] full packet");
    p0 = pop_total;
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    expectPacket(4);
    waitDrain(200, "t1");
    checkOutput("t1_pops", 32'(pop_total - p0), 32'd4);
    checkOutput("t1_qsize", 32'(qsize), 32'd0);
    checkOutput("t1_seq_num", 32'(seq_num), 32'(model_seq));

    // Partial packet flushed after the idle timeout.
    $display("[TB] partial flush");
    applyStimulus(8'hAA);
    applyStimulus(8'h55);
    expectPacket(2);
    n = 0;
    while (!(tx_valid && tx_sop) && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("t2_flush_delay", 32'(n), 32'd7);
    waitDrain(200, "t2");
    checkOutput("t2_qsize", 32'(qsize), 32'd0);

    // Same packet with a randomly stalling downstream.
    $display("[TB] random backpressure");
    rand_ready = 1'b1;
    p0 = pop_total;
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    expectPacket(4);
    waitDrain(400, "t3");
    rand_ready = 1'b0;
    checkOutput("t3_pops", 32'(pop_total - p0), 32'd4);

    // enable gating: nothing starts while low, running packet completes.
    $display("[TB] enable gating");
    enable = 1'b0;
    p0 = pop_total;
    for (int i = 0; i < 8; i++) applyStimulus(8'h60 + 8'(i));
    repeat (20) @(negedge clock);
    checkOutput("t6_no_pops", 32'(pop_total - p0), 32'd0);
    checkOutput("t6_idle_busy", 32'(busy), 32'd0);
    checkOutput("t6_qsize_held", 32'(qsize), 32'd8);
    expectPacket(4);
    enable = 1'b1;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput("t6_started", 32'(busy), 32'd1);
    repeat (3) @(negedge clock);
    enable = 1'b0;
    waitDrain(200, "t6a");
    repeat (20) @(negedge clock);
    checkOutput("t6_second_held", 32'(qsize), 32'd4);
    checkOutput("t6_second_busy", 32'(busy), 32'd0);
    expectPacket(4);
    enable = 1'b1;
    waitDrain(200, "t6b");
    checkOutput("t6_qsize", 32'(qsize), 32'd0);

    // 257 full packets so the sequence number wraps.
    $display("[TB] sequence wrap");
    for (int k = 0; k < 257; k++) begin
      for (int i = 0; i < 4; i++) begin
        r = 8'($urandom_range(0, 255));
        applyStimulus(r);
      end
      expectPacket(4);
      waitDrain(200, "t4");
    end
    checkOutput("t4_seq_num", 32'(seq_num), 32'(model_seq));

    // Clear while the second payload byte is presented.
    $display("[TB] clear mid-packet");
    applyStimulus(8'hC1);
    applyStimulus(8'hC2);
    applyStimulus(8'hC3);
    applyStimulus(8'hC4);
    expectPacket(4);
    found = 1'b0;
    n = 0;
    while (!found && n < 100) begin
      @(negedge clock);
      n++;
      if (tx_valid && !tx_sop && busy && tx_data == 8'hC2) found = 1'b1;
    end
    checkOutput("t5_reached_byte2", 32'(found), 32'd1);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    sb.delete();
    pend.delete();
    pend.push_back(8'hC3);
    pend.push_back(8'hC4);
    model_seq = 8'h00;
    checkOutput("t5_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_seq_num", 32'(seq_num), 32'd0);
    checkOutput("t5_sop_eop", 32'({tx_sop, tx_eop}), 32'd0);
    expectPacket(2);
    waitDrain(200, "t5");
    checkOutput("t5_qsize", 32'(qsize), 32'd0);
    checkOutput("t5_seq_after", 32'(seq_num), 32'(model_seq));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
